// File: rtl/dpram_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter.
// Four requesters share one set of lanes.
interface dpram_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter mapping four requesters
// onto the two ports of a 64x8 dual-port RAM.
module dpram_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  dpram_arbiter_if.slave  bus,
  output logic            ram_we_a,
  output logic            ram_we_b,
  output logic [5:0]      ram_addr_a,
  output logic [5:0]      ram_addr_b,
  output logic [7:0]      ram_data_a,
  output logic [7:0]      ram_data_b,
  input  logic [7:0]      ram_q_a,
  input  logic [7:0]      ram_q_b
);

  typedef struct packed {
    logic       v;
    logic       rd;
    logic [1:0] idx;
  } tag_t;

  logic [1:0]  ptr;
  logic        a_vld, b_vld, b_ok;
  logic [1:0]  a_idx, b_idx;
  logic [5:0]  a_addr, b_addr;
  logic        a_we, b_we;
  logic [7:0]  a_wd, b_wd;
  logic [3:0]  gnt;
  tag_t        t1_a, t1_b, t2_a, t2_b;
  logic [3:0]  rv_q, rv_nxt;
  logic [31:0] rd_q, rd_nxt;

  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    a_vld = 1'b0;
    b_vld = 1'b0;
    a_idx = '0;
    b_idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = idx;
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = idx;
        end
      end
    end
  end

  assign a_addr = bus.addr[6*a_idx +: 6];
  assign b_addr = bus.addr[6*b_idx +: 6];
  assign a_we   = bus.we[a_idx];
  assign b_we   = bus.we[b_idx];
  assign a_wd   = bus.wdata[8*a_idx +: 8];
  assign b_wd   = bus.wdata[8*b_idx +: 8];

  // Same-address pair involving a write: port A only
  assign b_ok = b_vld &&
    !((a_addr == b_addr) && (a_we || b_we));

  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (a_vld) gnt[a_idx] = 1'b1;
      if (b_ok)  gnt[b_idx] = 1'b1;
    end
  end

  assign bus.gnt = gnt;

  always_comb begin
    rv_nxt = '0;
    rd_nxt = rd_q;
    if (t2_a.v && t2_a.rd) begin
      rv_nxt[t2_a.idx] = 1'b1;
      rd_nxt[8*t2_a.idx +: 8] = ram_q_a;
    end
    if (t2_b.v && t2_b.rd) begin
      rv_nxt[t2_b.idx] = 1'b1;
      rd_nxt[8*t2_b.idx +: 8] = ram_q_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      ram_we_a   <= 1'b0;
      ram_we_b   <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_data_a <= '0;
      ram_data_b <= '0;
      t1_a       <= '0;
      t1_b       <= '0;
      t2_a       <= '0;
      t2_b       <= '0;
      rv_q       <= '0;
      rd_q       <= '0;
    end else begin
      if (a_vld)
        ptr <= (b_ok ? b_idx : a_idx) + 2'd1;
      ram_we_a <= a_vld && a_we;
      ram_we_b <= b_ok && b_we;
      if (a_vld) begin
        ram_addr_a <= a_addr;
        ram_data_a <= a_wd;
      end
      if (b_ok) begin
        ram_addr_b <= b_addr;
        ram_data_b <= b_wd;
      end
      // Two tag stages line up with the registered RAM q
      t1_a <= '{v: a_vld, rd: !a_we, idx: a_idx};
      t1_b <= '{v: b_ok,  rd: !b_we, idx: b_idx};
      t2_a <= t1_a;
      t2_b <= t1_b;
      rv_q <= rv_nxt;
      rd_q <= rd_nxt;
    end
  end

  assign bus.rvalid = rv_q;
  assign bus.rdata  = rd_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: RAM model, directed
// stimulus, scoreboard of expected read returns.
module tb_dpram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpram_arbiter_if bus ();

  logic       ram_we_a, ram_we_b;
  logic [5:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_data_a, ram_data_b;
  logic [7:0] ram_q_a, ram_q_b;
  logic [7:0] mem [64];

  dpram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
  );

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    else          ram_q_a <= mem[ram_addr_a];
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    else          ram_q_b <= mem[ram_addr_b];
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int         idx;
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.rvalid[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexp_rvalid req=%0d cyc=%0d",
                     i, cyc_n);
          end else begin
            me = sb.pop_front();
            chk("rv_idx", i, me.idx);
            chk("rv_data", {24'h0, bus.rdata[8*i +: 8]},
                {24'h0, me.d});
            chk("rv_cycle", cyc_n, me.c);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(int r, bit w, logic [5:0] a,
                        logic [7:0] d);
    bus.req[r] = 1'b1;
    bus.we[r]  = w;
    bus.addr[6*r +: 6]  = a;
    bus.wdata[8*r +: 8] = d;
  endtask

  task automatic clr();
    bus.req = '0;
    bus.we  = '0;
  endtask

  task automatic g(logic [3:0] e, string nm);
    #1;
    chk(nm, {28'h0, bus.gnt}, {28'h0, e});
  endtask

  task automatic exp_rd(int r, logic [7:0] d);
    exp_t e;
    e.idx = r;
    e.d   = d;
    e.c   = cyc_n + 3;
    sb.push_back(e);
  endtask

  task automatic chk_rst(string nm);
    chk({nm, "_gnt"}, {28'h0, bus.gnt}, 32'h0);
    chk({nm, "_rv"}, {28'h0, bus.rvalid}, 32'h0);
    chk({nm, "_rdata"}, bus.rdata, 32'h0);
    chk({nm, "_ram"},
        {2'b0, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b,
         ram_data_a, ram_data_b}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.req   = 4'hf;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    #2;
    chk_rst("reset");
    step();
    step();
    clr();
    rst_n = 1'b1;

    // write 0x5A to addr 3, idle, read back by req 2
    setreq(0, 1'b1, 6'd3, 8'h5a);
    g(4'b0001, "w0_gnt");
    step();
    clr();
    chk("w0_port", {22'h0, ram_we_a, ram_addr_a, ram_data_a},
        {22'h0, 1'b1, 6'd3, 8'h5a});
    step();
    chk("idle_port", {24'h0, ram_we_a, ram_addr_a, 1'b0},
        {24'h0, 1'b0, 6'd3, 1'b0});
    setreq(2, 1'b0, 6'd3, 8'h00);
    g(4'b0100, "r2_gnt");
    exp_rd(2, 8'h5a);
    step();
    clr();

    // preload through requester 3; ptr ends at 0
    for (int i = 0; i < 4; i++) begin
      setreq(3, 1'b1, 6'(i), 8'(8'ha0 + i));
      g(4'b1000, "pre_gnt");
      step();
      clr();
    end
    setreq(3, 1'b1, 6'd20, 8'h77);
    g(4'b1000, "pre_gnt");
    step();
    clr();
    chk("ptr0", {30'h0, dut.ptr}, 32'd0);
    step();
    step();

    // all four read, distinct addresses
    for (int r = 0; r < 4; r++)
      setreq(r, 1'b0, 6'(r), 8'h00);
    g(4'b0011, "rr1_gnt");
    exp_rd(0, 8'ha0);
    exp_rd(1, 8'ha1);
    step();
    chk("rr_ptr1", {30'h0, dut.ptr}, 32'd2);
    g(4'b1100, "rr2_gnt");
    exp_rd(2, 8'ha2);
    exp_rd(3, 8'ha3);
    step();
    chk("rr_ptr2", {30'h0, dut.ptr}, 32'd0);
    g(4'b0011, "rr3_gnt");
    exp_rd(0, 8'ha0);
    exp_rd(1, 8'ha1);
    step();
    clr();
    chk("rr_ptr3", {30'h0, dut.ptr}, 32'd2);

    setreq(3, 1'b0, 6'd0, 8'h00);
    g(4'b1000, "r3_gnt");
    exp_rd(3, 8'ha0);
    step();
    clr();
    chk("ptr_back0", {30'h0, dut.ptr}, 32'd0);

    // collision: write by 1 and read by 3 at addr 10
    setreq(1, 1'b1, 6'd10, 8'h11);
    setreq(3, 1'b0, 6'd10, 8'h00);
    g(4'b0010, "col1_gnt");
    step();
    clr();
    setreq(3, 1'b0, 6'd10, 8'h00);
    g(4'b1000, "col2_gnt");
    exp_rd(3, 8'h11);
    step();
    clr();

    // two reads of the same address
    setreq(0, 1'b0, 6'd20, 8'h00);
    setreq(1, 1'b0, 6'd20, 8'h00);
    g(4'b0011, "same_gnt");
    exp_rd(0, 8'h77);
    exp_rd(1, 8'h77);
    step();
    clr();

    // back-to-back reads by requester 0
    for (int i = 0; i < 4; i++) begin
      setreq(0, 1'b0, 6'(i), 8'h00);
      g(4'b0001, "b2b_gnt");
      exp_rd(0, 8'(8'ha0 + i));
      step();
    end
    clr();
    repeat (6) step();
    chk("drain", sb.size(), 32'd0);

    // read in flight, then reset
    setreq(0, 1'b0, 6'd3, 8'h00);
    g(4'b0001, "fl_gnt");
    step();
    rst_n = 1'b0;
    bus.req = 4'hf;
    #1;
    chk_rst("mid_rst");
    step();
    clr();
    step();
    rst_n = 1'b1;
    repeat (5) begin
      step();
      chk("post_rst_rv", {28'h0, bus.rvalid}, 32'h0);
    end
    chk("final_sb", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 The block SHALL have no parameters; the widths are fixed at 8-bit data, 6-bit address and 4 requesters, matching the team's 64x8 dual-port RAM.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester access request; bit i belongs to requester i.
REQ-005 we  input  4  per-requester write enable: 1 = write, 0 = read.
REQ-006 addr  input  24  per-requester address; requester i uses bits [6i+5:6i].
REQ-007 wdata  input  32  per-requester write data; requester i uses bits [8i+7:8i].
REQ-008 gnt  output  4  combinational grant; accepted transfer = req[i] & gnt[i] at a rising edge.
REQ-009 rvalid  output  4  registered one-cycle pulse; read data is available for requester i.
REQ-010 rdata  output  32  per-requester read-data lanes, using the same lane layout as wdata.
REQ-011 ram_we_a, ram_we_b  output  1 each  RAM port write enables (registered).
REQ-012 ram_addr_a, ram_addr_b  output  6 each  RAM port addresses (registered).
REQ-013 ram_data_a, ram_data_b  output  8 each  RAM port write data (registered).
REQ-014 ram_q_a, ram_q_b  input  8 each  RAM registered read data; q updates one edge after the address is presented and is not updated on a write.

Function
REQ-015 A 2-bit round-robin pointer ptr SHALL order the requesters for arbitration.
  - The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-016 Port allocation:
  - The first requesting index in search order SHALL be granted and assigned to port A.
  - The second requesting index SHALL be granted and assigned to port B, except as limited by REQ-017.
REQ-017 Collision rule: if both candidates use the same address and either candidate writes, only the port-A candidate SHALL be granted in that cycle.
  - Two reads of the same address SHALL both be granted.
REQ-018 gnt SHALL never assert for a requester whose req is 0, and SHALL have at most two bits set.
REQ-019 Pointer update: at each edge with at least one accepted transfer, ptr SHALL become (highest-priority-order last granted index + 1) mod 4.
  - With no accepted transfer, ptr SHALL hold.
REQ-020 At edge E of an accepted transfer, the assigned port's ram_we, ram_addr and ram_data SHALL register that requester's we, addr and wdata.
  - A port with no grant SHALL register ram_we=0 and hold its ram_addr and ram_data values.
REQ-021 Each port SHALL carry a two-stage tag pipeline (valid, read, index) that is aligned to the RAM latency.
REQ-022 Read latency: for a read accepted at edge E, rdata lane[idx] SHALL be loaded from that port's ram_q at edge E+2, and rvalid[idx] SHALL be 1 for exactly the cycle after E+2.
REQ-023 Accepted writes SHALL produce no rvalid.
  - Write order per port SHALL equal acceptance order.
  - A read accepted one or more cycles after a write to the same address SHALL return the written data.
REQ-024 A requester MAY hold req high for back-to-back transfers.
  - Each edge with req & gnt high SHALL count as one new transfer.
  - Pipelined reads SHALL each yield their own rvalid pulse in order.
REQ-025 An rdata lane SHALL hold its value until the next read completion for that requester.
REQ-026 Two completions for different requesters in the same cycle SHALL both assert their rvalid bits.
  - One requester cannot complete twice in the same cycle, because REQ-016 grants it at most once per cycle.

Reset
REQ-027 While rst_n=0, the block SHALL asynchronously force the following to 0:
  - ptr, both tag pipelines, rvalid and rdata;
  - ram_we_a/b, ram_addr_a/b and ram_data_a/b.
REQ-028 While rst_n=0, gnt SHALL be 0.
REQ-029 Reads in flight when reset asserts SHALL be discarded, with no rvalid after reset release.
REQ-030 Operation SHALL resume with the first rising edge at which rst_n=1.

Verification
REQ-031 Reset, then requester 0 writes 0x5A to address 3; one idle cycle; requester 2 reads address 3 -> rvalid[2] is asserted 2 edges after acceptance and rdata[23:16]=0x5A.
REQ-032 req=4'b1111, all reads, distinct addresses, ptr=0 -> gnt=0011; next cycle gnt=1100; next cycle gnt=0011; ptr sequence is 0, 2, 0.
REQ-033 Requesters 1 and 3 both target address 10, with requester 1 writing 0x11 and requester 3 reading, ptr=0 -> gnt=0010, then gnt=1000 on the following cycle, and requester 3 receives 0x11.
REQ-034 Requesters 0 and 1 both read address 20, which holds 0x77, in the same cycle -> gnt=0011, and rvalid=0011 in the same cycle with both lanes = 0x77.
REQ-035 Requester 0 holds req for 4 back-to-back reads of addresses 0-3, which hold 0xA0-0xA3 -> four consecutive rvalid[0] pulses carrying 0xA0, 0xA1, 0xA2, 0xA3.
REQ-036 Read accepted, then rst_n pulsed low at E+1 -> rvalid stays 0 through the 5 cycles after release, and all outputs read 0 during reset.
